wbs_pdm_rx: RTL and testbench



---
 rtl/wbs_pdm_rx_if.sv | 21 ++
 rtl/wbs_pdm_rx.sv | 169 ++++++++++++++++
 tb/tb_wbs_pdm_rx.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbs_pdm_rx_if.sv
// Wishbone B4 pipelined bus bundle for the PDM receiver register block.
interface wbs_pdm_rx_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_stall_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_stall_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_stall_o, wb_ack_o
  );
endinterface

// File: rtl/wbs_pdm_rx.sv
// PDM receiver: generates pdm_clk_o, counts ones over 2^BIT_RESOLUTION bits per PCM sample.
// Define WBS_PDM_RX_FIFO_EN to replace the single sample register with a 4-entry FIFO.
module wbs_pdm_rx #(
  parameter int unsigned BIT_RESOLUTION = 8,
  parameter int unsigned CLK_DIV        = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  wbs_pdm_rx_if.slave wb,
  output logic        pdm_clk_o,
  input  logic        pdm_dat_i
);
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0]           div_q, div_d;
  logic [BIT_RESOLUTION-1:0] bit_q, bit_d;
  logic [BIT_RESOLUTION:0]   ones_q, ones_d, ones_sum;
  logic [1:0]                sync_q;
  logic                      pclk_q, pclk_d;
  logic                      en_q, en_d;
  logic                      ovr_q, ovr_d, ovr_set;
  logic                      ack_q;
  logic [31:0]               dat_q, rdata;
  logic                      req, rd, wr, wrap, fall, done, pop_req, pop;
  logic                      valid, full;
  logic [BIT_RESOLUTION-1:0] new_sample, rd_sample;

  assign req     = wb.wb_cyc_i & wb.wb_stb_i;
  assign rd      = req & ~wb.wb_we_i;
  assign wr      = req & wb.wb_we_i;
  assign pop_req = rd & (wb.wb_adr_i == 4'h0);

  assign wrap     = en_q && (div_q == DivW'(CLK_DIV - 1));
  assign fall     = wrap & pclk_q;
  assign done     = fall && (bit_q == '1);
  assign ones_sum = ones_q + {{BIT_RESOLUTION{1'b0}}, sync_q[1]};
  // Only an all-ones window reaches 2^BIT_RESOLUTION, so the top bit flags saturation.
  assign new_sample = ones_sum[BIT_RESOLUTION] ? '1 : ones_sum[BIT_RESOLUTION-1:0];

  always_comb begin
    div_d  = '0;
    bit_d  = '0;
    ones_d = '0;
    pclk_d = 1'b0;
    if (en_q) begin
      div_d  = wrap ? '0 : div_q + 1'b1;
      bit_d  = bit_q;
      ones_d = ones_q;
      pclk_d = wrap ? ~pclk_q : pclk_q;
      if (fall) begin
        bit_d  = bit_q + 1'b1;
        ones_d = done ? '0 : ones_sum;
      end
    end
  end

`ifdef WBS_PDM_RX_FIFO_EN
  logic [BIT_RESOLUTION-1:0] mem_q [4];
  logic [1:0]                wp_q, rp_q;
  logic [2:0]                cnt_q, cnt_d;
  logic                      push;

  assign full      = (cnt_q == 3'd4);
  assign valid     = (cnt_q != 3'd0);
  assign pop       = pop_req & valid;
  assign push      = done & (~full | pop);
  assign ovr_set   = done & full & ~pop;
  assign rd_sample = valid ? mem_q[rp_q] : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 3'd1;
    else if (pop && !push) cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= new_sample;
        wp_q        <= wp_q + 2'd1;
      end
      if (pop) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_d;
    end
  end
`else
  logic [BIT_RESOLUTION-1:0] sample_q, sample_d;
  logic                      valid_q, valid_d;

  assign full      = 1'b0;
  assign valid     = valid_q;
  assign pop       = pop_req & valid_q;
  assign ovr_set   = done & valid_q & ~pop;
  assign rd_sample = sample_q;

  always_comb begin
    sample_d = sample_q;
    valid_d  = valid_q;
    if (done) begin
      sample_d = new_sample;
      valid_d  = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end
`endif

  always_comb begin
    en_d = en_q;
    if (wr && wb.wb_adr_i == 4'h2) en_d = wb.wb_dat_i[0];
    ovr_d = ovr_q;
    // A same-cycle overrun beats the W1C clear.
    if (ovr_set) ovr_d = 1'b1;
    else if (wr && wb.wb_adr_i == 4'h1 && wb.wb_dat_i[1]) ovr_d = 1'b0;
    case (wb.wb_adr_i)
      4'h0:    rdata = 32'(rd_sample);
      4'h1:    rdata = {29'd0, full, ovr_q, valid};
      4'h2:    rdata = {31'd0, en_q};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div_q  <= '0;
      bit_q  <= '0;
      ones_q <= '0;
      sync_q <= '0;
      pclk_q <= 1'b0;
      en_q   <= 1'b0;
      ovr_q  <= 1'b0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      ones_q <= ones_d;
      sync_q <= {sync_q[0], pdm_dat_i};
      pclk_q <= pclk_d;
      en_q   <= en_d;
      ovr_q  <= ovr_d;
      ack_q  <= req;
      if (req) dat_q <= rdata;
    end
  end

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_stall_o = 1'b0;
  assign pdm_clk_o     = pclk_q;

  logic unused_wdat;
  assign unused_wdat = ^wb.wb_dat_i[31:2];
endmodule

// File: tb/tb_wbs_pdm_rx.sv
// Randomised bench for wbs_pdm_rx against a window-level reference model of the sample store.
module tb_wbs_pdm_rx;
  localparam int unsigned BR = 4;
  localparam int unsigned CD = 2;
  localparam int WIN  = 1 << BR;
  localparam int SMAX = WIN - 1;
  localparam int FIRST_VALID = WIN * 2 * CD + 1;
`ifdef WBS_PDM_RX_FIFO_EN
  localparam bit FifoEn = 1'b1;
`else
  localparam bit FifoEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pdm_clk;
  logic pdm_dat = 1'b0;

  wbs_pdm_rx_if bus_if ();

  wbs_pdm_rx #(.BIT_RESOLUTION(BR), .CLK_DIV(CD)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus_if),
    .pdm_clk_o(pdm_clk),
    .pdm_dat_i(pdm_dat)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ack_bad = 0;

  // Reference model: counts consumed PDM bits per window, keeps samples in a list.
  bit  m_en, m_valid, m_ovr;
  int  m_sample;
  int  m_q[$];
  int  m_ones, m_nbits;
  bit  prev_pclk;
  int  mode;
  bit  alt;
  bit  cur_bit;
  bit  p_pop, p_wr;
  logic [3:0]  p_adr;
  logic [31:0] p_dat;

  function automatic bit next_bit();
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: begin alt = ~alt; return alt; end
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] adr);
    bit v, f;
    v = FifoEn ? (m_q.size() > 0) : m_valid;
    f = FifoEn && (m_q.size() == 4);
    case (adr)
      4'h0: begin
        if (FifoEn) return (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0;
        return 32'(m_sample);
      end
      4'h1:    return {29'd0, f, m_ovr, v};
      4'h2:    return {31'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_valid = 0; m_ovr = 0; m_sample = 0;
    m_q.delete(); m_ones = 0; m_nbits = 0; prev_pclk = 0;
  endtask

  task automatic set_mode(input int m);
    mode = m;
    alt = 1'b0;
    cur_bit = next_bit();
    pdm_dat = cur_bit;
  endtask

  // One clock: updates the model with pre-edge bus requests and any observed PDM falling edge.
  task automatic tick();
    bit fall, ovr_set;
    int s;
    @(posedge clk);
    #1;
    fall = m_en && prev_pclk && !pdm_clk;
    prev_pclk = pdm_clk;
    if (rst) begin
      model_reset();
    end else begin
      ovr_set = 0;
      if (p_pop) begin
        if (FifoEn) begin
          if (m_q.size() > 0) m_q.delete(0);
        end else m_valid = 0;
      end
      if (fall) begin
        m_ones += int'(cur_bit);
        m_nbits++;
        if (m_nbits == WIN) begin
          s = (m_ones > SMAX) ? SMAX : m_ones;
          if (FifoEn) begin
            if (m_q.size() == 4) ovr_set = 1;
            else m_q.push_back(s);
          end else begin
            if (m_valid) ovr_set = 1;
            m_sample = s;
            m_valid = 1;
          end
          m_ones = 0;
          m_nbits = 0;
        end
        cur_bit = next_bit();
        pdm_dat = cur_bit;
      end
      if (ovr_set) m_ovr = 1;
      else if (p_wr && p_adr == 4'h1 && p_dat[1]) m_ovr = 0;
      if (p_wr && p_adr == 4'h2) begin
        m_en = p_dat[0];
        if (!p_dat[0]) begin m_ones = 0; m_nbits = 0; end
      end
    end
    p_pop = 0;
    p_wr = 0;
  endtask

  task automatic bus(input bit we, input logic [3:0] adr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic [31:0] exp);
    exp = exp_read(adr);
    bus_if.wb_cyc_i = 1'b1;
    bus_if.wb_stb_i = 1'b1;
    bus_if.wb_we_i  = we;
    bus_if.wb_adr_i = adr;
    bus_if.wb_dat_i = wd;
    p_pop = !we && adr == 4'h0;
    p_wr  = we;
    p_adr = adr;
    p_dat = wd;
    tick();
    if (bus_if.wb_ack_o !== 1'b1 || bus_if.wb_stall_o !== 1'b0) ack_bad++;
    rd = bus_if.wb_dat_o;
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    bus_if.wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] wd);
    logic [31:0] rd, exp;
    bus(1'b1, adr, wd, rd, exp);
  endtask

  task automatic drain();
    logic [31:0] rd, exp;
    repeat (5) bus(1'b0, 4'h0, 32'd0, rd, exp);
    wr(4'h1, 32'h2);
  endtask

  // Polls STATUS back-to-back after an enable; returns the request index of first valid.
  task automatic poll_valid(input string tag, output int first_valid,
                            output int rise1, output int rise2);
    logic [31:0] rd, exp;
    bit lp;
    lp = pdm_clk;
    first_valid = 0; rise1 = 0; rise2 = 0;
    for (int n = 1; n <= 200 && first_valid == 0; n++) begin
      bus(1'b0, 4'h1, 32'd0, rd, exp);
      tests++;
      if (rd !== exp) begin
        fails++;
        $display("FAIL %s_status_poll n=%0d: got %0h want %0h", tag, n, rd, exp);
      end
      if (pdm_clk && !lp) begin
        if (rise1 == 0) rise1 = n;
        else if (rise2 == 0) rise2 = n;
      end
      lp = pdm_clk;
      if (rd[0]) first_valid = n;
    end
  endtask

  task automatic test_reset();
    int highs;
    logic [31:0] rd, exp;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if (bus_if.wb_ack_o !== 1'b0 || pdm_clk !== 1'b0 || bus_if.wb_dat_o !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got ack=%b pclk=%b dat=%0h want 0 0 0",
               bus_if.wb_ack_o, pdm_clk, bus_if.wb_dat_o);
    end
    for (int a = 0; a < 3; a++) begin
      bus(1'b0, 4'(a), 32'd0, rd, exp);
      tests++;
      if (rd !== 32'd0 || rd !== exp) begin
        fails++;
        $display("FAIL reset_reg%0d: got %0h want 0", a, rd);
      end
    end
    highs = 0;
    repeat (100) begin
      tick();
      if (pdm_clk !== 1'b0) highs++;
    end
    tests++;
    if (highs != 0) begin
      fails++;
      $display("FAIL idle_pdm_clk: got %0d high cycles want 0", highs);
    end
  endtask

  task automatic test_saturate();
    int fv, r1, r2;
    logic [31:0] rd, exp;
    set_mode(1);
    drain();
    wr(4'h2, 32'h1);
    poll_valid("sat", fv, r1, r2);
    tests++;
    if (r1 != CD || r2 != CD + 2 * CD) begin
      fails++;
      $display("FAIL pdm_clk_rises: got %0d,%0d want %0d,%0d", r1, r2, CD, 3 * CD);
    end
    tests++;
    if (fv != FIRST_VALID) begin
      fails++;
      $display("FAIL first_valid: got %0d want %0d", fv, FIRST_VALID);
    end
    bus(1'b0, 4'h0, 32'd0, rd, exp);
    tests++;
    if (rd !== exp || rd !== 32'(SMAX)) begin
      fails++;
      $display("FAIL sat_sample: got %0h want %0h", rd, SMAX);
    end
    bus(1'b0, 4'h1, 32'd0, rd, exp);
    tests++;
    if (rd !== exp || rd[0] !== 1'b0) begin
      fails++;
      $display("FAIL sat_popped_status: got %0h want %0h", rd, exp);
    end
    wr(4'h2, 32'h0);
  endtask

  task automatic test_patterns();
    int fv, r1, r2;
    int want;
    logic [31:0] rd, exp;
    for (int k = 0; k < 2; k++) begin
      wr(4'h2, 32'h0);
      set_mode(k == 0 ? 2 : 0);
      want = (k == 0) ? WIN / 2 : 0;
      drain();
      wr(4'h2, 32'h1);
      poll_valid("pat", fv, r1, r2);
      bus(1'b0, 4'h0, 32'd0, rd, exp);
      tests++;
      if (rd !== exp || rd !== 32'(want)) begin
        fails++;
        $display("FAIL pattern%0d_sample: got %0h want %0h (model %0h)", k, rd, want, exp);
      end
    end
    wr(4'h2, 32'h0);
  endtask

  task automatic test_overrun();
    logic [31:0] rd, exp;
    set_mode(3);
    drain();
    wr(4'h2, 32'h1);
    repeat (2 * WIN * 2 * CD + 12) tick();
    bus(1'b0, 4'h1, 32'd0, rd, exp);
    tests++;
    if (rd !== exp) begin
      fails++;
      $display("FAIL ovr_status: got %0h want %0h", rd, exp);
    end
`ifndef WBS_PDM_RX_FIFO_EN
    tests++;
    if (rd !== 32'h3) begin
      fails++;
      $display("FAIL ovr_status_bits: got %0h want 3", rd);
    end
`endif
    wr(4'h1, 32'h2);
    bus(1'b0, 4'h1, 32'd0, rd, exp);
    tests++;
    if (rd !== exp || rd[1:0] !== 2'b01) begin
      fails++;
      $display("FAIL ovr_cleared: got %0h want %0h", rd, exp);
    end
    bus(1'b0, 4'h0, 32'd0, rd, exp);
    tests++;
    if (rd !== exp) begin
      fails++;
      $display("FAIL ovr_latest: got %0h want %0h", rd, exp);
    end
    wr(4'h2, 32'h0);
  endtask

  task automatic test_disable();
    int highs, fv, r1, r2;
    logic [31:0] rd, exp;
    set_mode(1);
    drain();
    wr(4'h2, 32'h1);
    repeat (30) tick();
    wr(4'h2, 32'h0);
    highs = 0;
    repeat (50) begin
      tick();
      if (pdm_clk !== 1'b0) highs++;
    end
    tests++;
    if (highs != 0) begin
      fails++;
      $display("FAIL disabled_pdm_clk: got %0d high cycles want 0", highs);
    end
    wr(4'h2, 32'h1);
    poll_valid("reen", fv, r1, r2);
    tests++;
    if (fv != FIRST_VALID) begin
      fails++;
      $display("FAIL reenable_first_valid: got %0d want %0d", fv, FIRST_VALID);
    end
    bus(1'b0, 4'h0, 32'd0, rd, exp);
    tests++;
    if (rd !== exp || rd !== 32'(SMAX)) begin
      fails++;
      $display("FAIL reenable_sample: got %0h want %0h", rd, SMAX);
    end
    wr(4'h2, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp, wd;
    logic [3:0] adr;
    bit we;
    set_mode(3);
    drain();
    wr(4'h2, 32'h1);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        tick();
      end else begin
        adr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
        we  = ($urandom_range(0, 3) == 0);
        wd  = $urandom;
        if (adr == 4'h2) wd[0] = ($urandom_range(0, 5) != 0);
        bus(we, adr, wd, rd, exp);
        if (!we) begin
          tests++;
          if (rd !== exp) begin
            fails++;
            $display("FAIL b2b_read%0d adr=%0h: got %0h want %0h", i, adr, rd, exp);
          end
        end
      end
    end
    tick();
    tests++;
    if (bus_if.wb_ack_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_ack: got %b want 0", bus_if.wb_ack_o);
    end
    tests++;
    if (ack_bad != 0) begin
      fails++;
      $display("FAIL ack_every_request: got %0d missing acks want 0", ack_bad);
    end
    wr(4'h2, 32'h0);
  endtask

  task automatic test_reset_mid();
    int fv, r1, r2;
    logic [31:0] rd, exp;
    set_mode(1);
    drain();
    wr(4'h2, 32'h1);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (pdm_clk !== 1'b0) begin
      fails++;
      $display("FAIL midreset_pdm_clk: got %b want 0", pdm_clk);
    end
    bus(1'b0, 4'h2, 32'd0, rd, exp);
    tests++;
    if (rd !== exp || rd !== 32'd0) begin
      fails++;
      $display("FAIL midreset_ctrl: got %0h want 0", rd);
    end
    wr(4'h2, 32'h1);
    poll_valid("mrst", fv, r1, r2);
    tests++;
    if (fv != FIRST_VALID) begin
      fails++;
      $display("FAIL midreset_first_valid: got %0d want %0d", fv, FIRST_VALID);
    end
    wr(4'h2, 32'h0);
  endtask

`ifdef WBS_PDM_RX_FIFO_EN
  task automatic test_fifo();
    logic [31:0] rd, exp;
    set_mode(3);
    drain();
    wr(4'h2, 32'h1);
    repeat (5 * WIN * 2 * CD + 12) tick();
    bus(1'b0, 4'h1, 32'd0, rd, exp);
    tests++;
    if (rd !== exp || rd !== 32'h7) begin
      fails++;
      $display("FAIL fifo_full_status: got %0h want 7 (model %0h)", rd, exp);
    end
    wr(4'h2, 32'h0);
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, 4'h0, 32'd0, rd, exp);
      tests++;
      if (rd !== exp) begin
        fails++;
        $display("FAIL fifo_read%0d: got %0h want %0h", i, rd, exp);
      end
    end
    bus(1'b0, 4'h1, 32'd0, rd, exp);
    tests++;
    if (rd !== exp || rd[0] !== 1'b0) begin
      fails++;
      $display("FAIL fifo_empty_status: got %0h want %0h", rd, exp);
    end
  endtask
`endif

  initial begin
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    bus_if.wb_we_i  = 1'b0;
    bus_if.wb_adr_i = 4'h0;
    bus_if.wb_dat_i = 32'd0;
    p_pop = 0;
    p_wr  = 0;
    p_adr = '0;
    p_dat = '0;
    model_reset();
    set_mode(0);
    test_reset();
    test_saturate();
    test_patterns();
    test_overrun();
    test_disable();
    test_back_to_back();
    test_reset_mid();
`ifdef WBS_PDM_RX_FIFO_EN
    test_fifo();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
